// File: rtl/pulse_gen_pkg.sv
`default_nettype none
// =====================================================================
// pulse_gen_pkg : shared types for the multi-channel pulse generator
// Rev 1.0
// =====================================================================
package pulse_gen_pkg;

   localparam int PG_CNT_W   = 16;
   localparam int PG_BURST_W = 8;

   typedef enum logic [1:0] {
      PG_CONT    = 2'd0,
      PG_ONESHOT = 2'd1,
      PG_BURST   = 2'd2,
      PG_RSVD    = 2'd3
   } pg_mode_e;

   typedef enum logic [0:0] {
      PG_IDLE = 1'b0,
      PG_RUN  = 1'b1
   } pg_state_e;

   typedef struct packed {
      logic [PG_CNT_W-1:0]   period;
      logic [PG_CNT_W-1:0]   duty;
      pg_mode_e              mode;
      logic [PG_BURST_W-1:0] burst;
   } pg_cfg_t;

endpackage
`default_nettype wire

// File: rtl/pulse_gen_channel.sv
`default_nettype none
// =====================================================================
// pulse_gen_channel : one pulse/PWM channel with shadowed configuration
// Rev 1.0
// =====================================================================
module pulse_gen_channel
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_wr,
   input  logic [CNT_W-1:0]   i_period,
   input  logic [CNT_W-1:0]   i_duty,
   input  logic [1:0]         i_mode,
   input  logic [BURST_W-1:0] i_burst,
   input  logic               i_start,
   input  logic               i_stop,
   output logic               o_pulse,
   output logic               o_busy,
   output logic               o_done
);

   typedef struct packed {
      logic [CNT_W-1:0]   period;
      logic [CNT_W-1:0]   duty;
      pg_mode_e           mode;
      logic [BURST_W-1:0] burst;
   } ch_cfg_t;

   ch_cfg_t            shadow_q, shadow_d;
   ch_cfg_t            active_q, active_d;
   pg_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BURST_W-1:0] per_idx_q, per_idx_d;
   logic               pulse_q, pulse_d;
   logic               done_q, done_d;

   logic               w_wrap;
   logic               w_last_period;
   logic [BURST_W-1:0] w_limit_m1;

   // Index of the final period; burst=0 is treated as a single period.
   always_comb begin
      w_limit_m1 = '0;
      if (active_q.mode == PG_BURST && active_q.burst != '0) begin
         w_limit_m1 = active_q.burst - BURST_W'(1);
      end
   end

   assign w_wrap        = (cnt_q == active_q.period - CNT_W'(1));
   assign w_last_period = (active_q.mode != PG_CONT) && (per_idx_q >= w_limit_m1);

   always_comb begin
      shadow_d = shadow_q;
      if (i_wr) begin
         shadow_d.period = i_period;
         shadow_d.duty   = i_duty;
         shadow_d.mode   = pg_mode_e'(i_mode);
         shadow_d.burst  = i_burst;
      end

      active_d  = active_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      per_idx_d = per_idx_q;
      done_d    = 1'b0;

      // Loads below read shadow_q so a same-cycle write waits for the next boundary.
      case (state_q)
         PG_IDLE: begin
            if (i_start && !i_stop && shadow_q.period != '0) begin
               state_d   = PG_RUN;
               cnt_d     = '0;
               per_idx_d = '0;
               active_d  = shadow_q;
            end
         end
         PG_RUN: begin
            if (i_stop) begin
               state_d   = PG_IDLE;
               cnt_d     = '0;
               per_idx_d = '0;
            end else if (w_wrap) begin
               cnt_d = '0;
               if (w_last_period) begin
                  state_d   = PG_IDLE;
                  per_idx_d = '0;
                  done_d    = 1'b1;
               end else begin
                  active_d  = shadow_q;
                  per_idx_d = (active_q.mode == PG_CONT || shadow_q.mode == PG_CONT)
                              ? '0 : per_idx_q + BURST_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = PG_IDLE;
         end
      endcase

      pulse_d = (state_d == PG_RUN) && (cnt_d < active_d.duty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q  <= '0;
         active_q  <= '0;
         state_q   <= PG_IDLE;
         cnt_q     <= '0;
         per_idx_q <= '0;
         pulse_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         per_idx_q <= per_idx_d;
         pulse_q   <= pulse_d;
         done_q    <= done_d;
      end
   end

   assign o_pulse = pulse_q;
   assign o_busy  = (state_q == PG_RUN);
   assign o_done  = done_q;

endmodule
`default_nettype wire

// File: rtl/pulse_gen_multi.sv
`default_nettype none
// =====================================================================
// pulse_gen_multi : NUM_CH independent programmable pulse/PWM channels
// Rev 1.0
// =====================================================================
module pulse_gen_multi
   import pulse_gen_pkg::*;
#(
   parameter  int NUM_CH  = 4,
   parameter  int CNT_W   = 16,
   parameter  int BURST_W = 8,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_cfg_wr,
   input  logic [CH_W-1:0]    i_cfg_ch,
   input  logic [CNT_W-1:0]   i_cfg_period,
   input  logic [CNT_W-1:0]   i_cfg_duty,
   input  logic [1:0]         i_cfg_mode,
   input  logic [BURST_W-1:0] i_cfg_burst,
   input  logic [NUM_CH-1:0]  i_start,
   input  logic [NUM_CH-1:0]  i_stop,
   output logic [NUM_CH-1:0]  o_pulse,
   output logic [NUM_CH-1:0]  o_busy,
   output logic [NUM_CH-1:0]  o_done
);

   // Channel indices past NUM_CH-1 match no channel, so such writes drop.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic w_wr;

      assign w_wr = i_cfg_wr && (i_cfg_ch == CH_W'(g));

      pulse_gen_channel #(
         .CNT_W   (CNT_W),
         .BURST_W (BURST_W)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .i_wr     (w_wr),
         .i_period (i_cfg_period),
         .i_duty   (i_cfg_duty),
         .i_mode   (i_cfg_mode),
         .i_burst  (i_cfg_burst),
         .i_start  (i_start[g]),
         .i_stop   (i_stop[g]),
         .o_pulse  (o_pulse[g]),
         .o_busy   (o_busy[g]),
         .o_done   (o_done[g])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen_multi.sv
`default_nettype none
// =====================================================================
// tb_pulse_gen_multi : directed + model-driven bench for pulse_gen_multi
// Rev 1.0
// =====================================================================
module tb_pulse_gen_multi;
   import pulse_gen_pkg::*;

   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 16;
   localparam int BURST_W = 8;

   logic               clk;
   logic               rst;
   logic               i_cfg_wr;
   logic [1:0]         i_cfg_ch;
   logic [CNT_W-1:0]   i_cfg_period;
   logic [CNT_W-1:0]   i_cfg_duty;
   logic [1:0]         i_cfg_mode;
   logic [BURST_W-1:0] i_cfg_burst;
   logic [NUM_CH-1:0]  i_start;
   logic [NUM_CH-1:0]  i_stop;
   logic [NUM_CH-1:0]  o_pulse;
   logic [NUM_CH-1:0]  o_busy;
   logic [NUM_CH-1:0]  o_done;

   pulse_gen_multi #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_cfg_wr     (i_cfg_wr),
      .i_cfg_ch     (i_cfg_ch),
      .i_cfg_period (i_cfg_period),
      .i_cfg_duty   (i_cfg_duty),
      .i_cfg_mode   (i_cfg_mode),
      .i_cfg_burst  (i_cfg_burst),
      .i_start      (i_start),
      .i_stop       (i_stop),
      .o_pulse      (o_pulse),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int    cyc;
      int    ch;
      string tag;
      logic  p;
      logic  b;
      logic  d;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference model state for the free-running phase
   logic    m_run  [NUM_CH];
   logic    m_done [NUM_CH];
   int      m_pos  [NUM_CH];
   int      m_nper [NUM_CH];
   pg_cfg_t m_act  [NUM_CH];
   pg_cfg_t m_shd  [NUM_CH];
   int      mode_tab [NUM_CH] = '{0, 2, 1, 2};

   function automatic string rep(input string c, input int n);
      string s;
      s = "";
      for (int k = 0; k < n; k++) s = {s, c};
      return s;
   endfunction

   task automatic check_bit(input string tag, input int ch, input string what,
                            input logic obs, input logic exp_v);
      n_chk++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s ch%0d cyc%0d %s: got %b expected %b", tag, ch, cyc, what, obs, exp_v);
   endtask

   task automatic push(input string tag, input int ch, input int at,
                       input logic p, input logic b, input logic d);
      exp_t e;
      e.cyc = at; e.ch = ch; e.tag = tag; e.p = p; e.b = b; e.d = d;
      exp_q.push_back(e);
   endtask

   // Advance one clock, then compare every expectation scheduled for this cycle.
   task automatic tick();
      exp_t e;
      int   i;
      @(posedge clk);
      #1;
      cyc++;
      i = 0;
      while (i < exp_q.size()) begin
         if (exp_q[i].cyc <= cyc) begin
            e = exp_q[i];
            exp_q.delete(i);
            check_bit(e.tag, e.ch, "pulse", o_pulse[e.ch], e.p);
            check_bit(e.tag, e.ch, "busy",  o_busy[e.ch],  e.b);
            check_bit(e.tag, e.ch, "done",  o_done[e.ch],  e.d);
         end else begin
            i++;
         end
      end
   endtask

   task automatic expect_pat(input string tag, input int ch,
                             input string p, input string b, input string d);
      for (int k = 0; k < p.len(); k++)
         push(tag, ch, cyc + 1 + k, p[k] == "1", b[k] == "1", d[k] == "1");
   endtask

   task automatic expect_idle(input string tag, input int n);
      for (int k = 0; k < n; k++)
         for (int c = 0; c < NUM_CH; c++)
            push(tag, c, cyc + 1 + k, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic set_cfg(input int ch, input int period, input int duty,
                          input int mode, input int burst);
      i_cfg_wr     = 1'b1;
      i_cfg_ch     = 2'(ch);
      i_cfg_period = CNT_W'(period);
      i_cfg_duty   = CNT_W'(duty);
      i_cfg_mode   = 2'(mode);
      i_cfg_burst  = BURST_W'(burst);
   endtask

   task automatic cfg_write(input int ch, input int period, input int duty,
                            input int mode, input int burst);
      set_cfg(ch, period, duty, mode, burst);
      tick();
      i_cfg_wr = 1'b0;
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_run[c] = 1'b0; m_done[c] = 1'b0; m_pos[c] = 0; m_nper[c] = 0;
         m_act[c] = '0;   m_shd[c]  = '0;
      end
   endtask

   // Behavioural model: pos/periods-completed view of each channel.
   task automatic mstep();
      int      total;
      pg_cfg_t shd_old;
      for (int c = 0; c < NUM_CH; c++) begin
         shd_old = m_shd[c];
         if (i_cfg_wr && int'(i_cfg_ch) == c) begin
            m_shd[c].period = i_cfg_period;
            m_shd[c].duty   = i_cfg_duty;
            m_shd[c].mode   = pg_mode_e'(i_cfg_mode);
            m_shd[c].burst  = i_cfg_burst;
         end
         m_done[c] = 1'b0;
         if (!m_run[c]) begin
            if (i_start[c] && !i_stop[c] && shd_old.period != 0) begin
               m_run[c] = 1'b1; m_pos[c] = 0; m_nper[c] = 0; m_act[c] = shd_old;
            end
         end else if (i_stop[c]) begin
            m_run[c] = 1'b0;
         end else if (m_pos[c] + 1 == int'(m_act[c].period)) begin
            m_nper[c]++;
            case (m_act[c].mode)
               PG_CONT:  total = 0;
               PG_BURST: total = (m_act[c].burst == 0) ? 1 : int'(m_act[c].burst);
               default:  total = 1;
            endcase
            if (total != 0 && m_nper[c] >= total) begin
               m_run[c] = 1'b0; m_done[c] = 1'b1;
            end else begin
               m_pos[c] = 0; m_act[c] = shd_old;
               if (total == 0) m_nper[c] = 0;
            end
         end else begin
            m_pos[c]++;
         end
         push("model", c, cyc + 1, m_run[c] && (m_pos[c] < int'(m_act[c].duty)),
              m_run[c], m_done[c]);
      end
      tick();
   endtask

   initial begin
      rst = 1'b1; i_cfg_wr = 1'b0; i_cfg_ch = '0; i_cfg_period = '0; i_cfg_duty = '0;
      i_cfg_mode = '0; i_cfg_burst = '0; i_start = '0; i_stop = '0;

      expect_idle("reset", 2);
      tick(); tick();
      rst = 1'b0;
      expect_idle("post_reset", 1);
      tick();

      // CONT ch0 period 5 duty 2, then stop
      cfg_write(0, 5, 2, 0, 0);
      i_start = 4'b0001;
      expect_pat("cont", 0, "110001100011000", rep("1", 15), rep("0", 15));
      tick(); i_start = '0;
      repeat (14) tick();
      i_stop = 4'b0001;
      expect_pat("cont_stop", 0, "00", "00", "00");
      tick(); i_stop = '0; tick();

      // ONESHOT ch1
      cfg_write(1, 4, 1, 1, 0);
      i_start = 4'b0010;
      expect_pat("oneshot", 1, "100000", "111100", "000010");
      tick(); i_start = '0; repeat (5) tick();

      // BURST 3 and BURST 0
      cfg_write(1, 4, 1, 2, 3);
      i_start = 4'b0010;
      expect_pat("burst3", 1, "10001000100000", "11111111111100", "00000000000010");
      tick(); i_start = '0; repeat (13) tick();
      cfg_write(1, 4, 1, 2, 0);
      i_start = 4'b0010;
      expect_pat("burst0", 1, "100000", "111100", "000010");
      tick(); i_start = '0; repeat (5) tick();

      // Back-to-back: restart in the done cycle
      cfg_write(1, 4, 1, 1, 0);
      i_start = 4'b0010;
      expect_pat("b2b", 1, "10000100000", "11110111100", "00001000010");
      tick(); i_start = '0; repeat (4) tick();
      i_start = 4'b0010;
      tick(); i_start = '0; repeat (5) tick();

      // Glitch-free update: mid-period write, then a write on the wrap cycle
      cfg_write(0, 6, 3, 0, 0);
      i_start = 4'b0001;
      expect_pat("glitch", 0, "11100010001000110110", rep("1", 20), rep("0", 20));
      tick(); i_start = '0; tick();
      cfg_write(0, 4, 1, 0, 0);
      repeat (7) tick();
      cfg_write(0, 3, 2, 0, 0);
      repeat (9) tick();
      i_stop = 4'b0001;
      expect_pat("glitch_stop", 0, "0", "0", "0");
      tick(); i_stop = '0;

      // duty=0 and duty>=period on ch2
      cfg_write(2, 4, 0, 0, 0);
      i_start = 4'b0100;
      expect_pat("duty0", 2, rep("0", 8), rep("1", 8), rep("0", 8));
      tick(); i_start = '0; repeat (7) tick();
      i_stop = 4'b0100;
      expect_pat("duty0_stop", 2, "0", "0", "0");
      tick(); i_stop = '0;
      cfg_write(2, 4, 9, 0, 0);
      i_start = 4'b0100;
      expect_pat("duty9", 2, rep("1", 8), rep("1", 8), rep("0", 8));
      tick(); i_start = '0; repeat (7) tick();
      i_stop = 4'b0100;
      expect_pat("duty9_stop", 2, "0", "0", "0");
      tick(); i_stop = '0;

      // period=0 start ignored
      cfg_write(2, 0, 2, 0, 0);
      i_start = 4'b0100;
      expect_pat("period0", 2, "000", "000", "000");
      tick(); i_start = '0; tick(); tick();

      // Start while running keeps phase
      cfg_write(2, 5, 2, 0, 0);
      i_start = 4'b0100;
      expect_pat("restart", 2, "1100011000", rep("1", 10), rep("0", 10));
      tick(); i_start = '0; tick(); tick();
      i_start = 4'b0100;
      tick(); i_start = '0; repeat (6) tick();
      i_stop = 4'b0100;
      expect_pat("restart_stop", 2, "0", "0", "0");
      tick(); i_stop = '0;

      // Stop at cnt=2, then start+stop together
      cfg_write(3, 5, 4, 1, 0);
      i_start = 4'b1000;
      expect_pat("stop_cnt2", 3, "11100", "11100", "00000");
      tick(); i_start = '0; tick(); tick();
      i_stop = 4'b1000;
      tick(); i_stop = '0; tick();
      i_start = 4'b1000; i_stop = 4'b1000;
      expect_pat("start_stop", 3, "000", "000", "000");
      tick(); i_start = '0; i_stop = '0; tick(); tick();

      // Reset mid-BURST clears outputs and config
      cfg_write(1, 4, 1, 2, 3);
      i_start = 4'b0010;
      expect_pat("pre_rst", 1, "10001", "11111", "00000");
      tick(); i_start = '0; repeat (4) tick();
      rst = 1'b1;
      expect_idle("rst_mid", 2);
      tick(); tick();
      rst = 1'b0;
      i_start = 4'b0011;
      expect_pat("cfg_cleared", 0, "000", "000", "000");
      expect_pat("cfg_cleared", 1, "000", "000", "000");
      tick(); i_start = '0; tick(); tick();

      // Free-running multi-channel phase against the reference model
      rst = 1'b1;
      expect_idle("model_rst", 1);
      tick();
      rst = 1'b0;
      model_reset();
      set_cfg(0, 5, 2, 0, 0); mstep();
      set_cfg(1, 7, 3, 2, 4); mstep();
      set_cfg(2, 6, 4, 1, 0); mstep();
      set_cfg(3, 4, 1, 2, 2); mstep();
      i_cfg_wr = 1'b0;
      for (int n = 0; n < 200; n++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            i_start[c] = ($urandom_range(3) == 0);
            i_stop[c]  = ($urandom_range(29) == 0);
         end
         if ($urandom_range(4) == 0) begin
            i_cfg_ch = 2'($urandom_range(3));
            set_cfg(int'(i_cfg_ch), $urandom_range(8, 1), $urandom_range(9),
                    mode_tab[i_cfg_ch], $urandom_range(3));
         end else begin
            i_cfg_wr = 1'b0;
         end
         mstep();
      end
      i_start = '0; i_stop = '0; i_cfg_wr = 1'b0;
      repeat (5) mstep();

      n_chk++;
      assert (exp_q.size() == 0) n_pass++;
      else $error("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
